spike_collector: RTL

- Gathers spike events from NUM_NEURONS LIF neuron instances into one ordered output stream.
- Sits directly downstream of the per-neuron spike_valid/spike_id/spike_ready outputs.
- Holds one pending spike per neuron, arbitrates round-robin into a first-word-fall-through FIFO, and tags each event with a scan timestamp.
- Neuron spikes are single-cycle pulses, so capture is never stalled by the downstream consumer except through the one-deep pending slot.

---
 rtl/spike_collector.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/spike_collector.sv
// spike_collector: gathers per-neuron spike pulses into one timestamped stream.
// Each neuron owns a one-deep pending slot. A round-robin arbiter moves one
// pending slot per cycle into a first-word-fall-through FIFO. Every event
// carries the scan timestamp that was current when the spike was captured.

// One pending slot per neuron. A slot can accept a new spike in the same
// cycle that it is granted, so back-to-back pulses from one neuron are kept.
module spike_slot #(
  parameter int ID_W = 4,
  parameter int TS_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_valid,
  input  logic [ID_W-1:0] i_id,
  input  logic [TS_W-1:0] i_ts,
  input  logic            i_grant,
  output logic            o_ready,
  output logic            o_pend,
  output logic            o_drop,
  output logic [ID_W-1:0] o_id,
  output logic [TS_W-1:0] o_ts
);
  logic            r_pend;
  logic [ID_W-1:0] r_id;
  logic [TS_W-1:0] r_ts;
  logic            w_cap;

  assign o_ready = ~r_pend | i_grant;
  assign w_cap   = i_valid & o_ready;
  assign o_drop  = i_valid & ~o_ready;
  assign o_pend  = r_pend;
  assign o_id    = r_id;
  assign o_ts    = r_ts;

  // Capture wins over grant-clear, so a recapture keeps the slot pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend <= 1'b0;
      r_id   <= '0;
      r_ts   <= '0;
    end else if (w_cap) begin
      r_pend <= 1'b1;
      r_id   <= i_id;
      r_ts   <= i_ts;
    end else if (i_grant) begin
      r_pend <= 1'b0;
    end
  end
endmodule

module spike_collector #(
  parameter int NUM_NEURONS = 8,
  parameter int NEURON_ID_W = 4,
  parameter int FIFO_DEPTH  = 16,
  parameter int TS_W        = 8,
  parameter int DROP_W      = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               scan_start_en,
  input  logic [NUM_NEURONS-1:0]             spike_valid_in,
  input  logic [NUM_NEURONS*NEURON_ID_W-1:0] spike_id_in,
  output logic [NUM_NEURONS-1:0]             spike_ready_out,
  output logic                               out_valid,
  output logic [NEURON_ID_W-1:0]             out_id,
  output logic [TS_W-1:0]                    out_ts,
  input  logic                               out_ready,
  output logic [$clog2(FIFO_DEPTH):0]        fifo_count,
  output logic [DROP_W-1:0]                  drop_count
);
  localparam int PTR_W = $clog2(NUM_NEURONS);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CNT_W = AW + 1;
  localparam int DCW   = $clog2(NUM_NEURONS + 1);
  localparam int SW    = DROP_W + DCW;
  localparam int EW    = NEURON_ID_W + TS_W;

  localparam logic [PTR_W:0]    NN        = (PTR_W+1)'(NUM_NEURONS);
  localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);
  localparam logic [DROP_W-1:0] DROP_MAX  = '1;

  logic [TS_W-1:0]  r_ts;
  logic [PTR_W-1:0] r_ptr;
  logic [CNT_W-1:0] r_count;
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [EW-1:0]    r_mem [FIFO_DEPTH];
  logic [NEURON_ID_W-1:0] r_out_id;
  logic [TS_W-1:0]        r_out_ts;
  logic [DROP_W-1:0]      r_drop;

  logic [NUM_NEURONS-1:0]                  w_pend;
  logic [NUM_NEURONS-1:0]                  w_drop;
  logic [NUM_NEURONS-1:0]                  w_grant;
  logic [NUM_NEURONS-1:0][NEURON_ID_W-1:0] w_slot_id;
  logic [NUM_NEURONS-1:0][TS_W-1:0]        w_slot_ts;

  logic             w_full;
  logic             w_gnt_vld;
  logic [PTR_W-1:0] w_gnt_sel;
  logic [PTR_W:0]   w_idx;
  logic             w_push;
  logic             w_pop;
  logic [EW-1:0]    w_push_data;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [AW-1:0]    w_rd_nxt;
  logic [DCW-1:0]   w_ndrop;
  logic [SW-1:0]    w_drop_sum;
  logic [DROP_W-1:0] w_drop_nxt;

  for (genvar g = 0; g < NUM_NEURONS; g++) begin : g_slot
    spike_slot #(.ID_W(NEURON_ID_W), .TS_W(TS_W)) u_slot (
      .clk     (clk),
      .rst     (rst),
      .i_valid (spike_valid_in[g]),
      .i_id    (spike_id_in[g*NEURON_ID_W +: NEURON_ID_W]),
      .i_ts    (r_ts),
      .i_grant (w_grant[g]),
      .o_ready (spike_ready_out[g]),
      .o_pend  (w_pend[g]),
      .o_drop  (w_drop[g]),
      .o_id    (w_slot_id[g]),
      .o_ts    (w_slot_ts[g])
    );
  end

  assign w_full = (r_count == DEPTH_C);

  // Round-robin pick: first pending slot after the last winner, wrapping.
  always_comb begin
    w_grant   = '0;
    w_gnt_vld = 1'b0;
    w_gnt_sel = '0;
    w_idx     = '0;
    for (int k = 1; k <= NUM_NEURONS; k++) begin
      w_idx = {1'b0, r_ptr} + (PTR_W+1)'(k);
      if (w_idx >= NN) w_idx = w_idx - NN;
      if (!w_gnt_vld && !w_full && w_pend[w_idx[PTR_W-1:0]]) begin
        w_gnt_vld = 1'b1;
        w_gnt_sel = w_idx[PTR_W-1:0];
      end
    end
    if (w_gnt_vld) w_grant[w_gnt_sel] = 1'b1;
  end

  assign w_push      = w_gnt_vld;
  assign w_pop       = (r_count != '0) & out_ready;
  assign w_push_data = {w_slot_id[w_gnt_sel], w_slot_ts[w_gnt_sel]};
  assign w_cnt_nxt   = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
  assign w_rd_nxt    = r_rd + AW'(w_pop);

  // Count simultaneous losses and add them with saturation.
  always_comb begin
    w_ndrop = '0;
    for (int i = 0; i < NUM_NEURONS; i++) w_ndrop = w_ndrop + DCW'(w_drop[i]);
    w_drop_sum = SW'(r_drop) + SW'(w_ndrop);
    w_drop_nxt = (w_drop_sum > SW'(DROP_MAX)) ? DROP_MAX : w_drop_sum[DROP_W-1:0];
  end

  // Scan timestamp, arbiter pointer, FIFO pointers and drop counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ts    <= '0;
      r_ptr   <= PTR_W'(NUM_NEURONS - 1);
      r_count <= '0;
      r_wr    <= '0;
      r_rd    <= '0;
      r_drop  <= '0;
    end else begin
      if (scan_start_en) r_ts <= r_ts + TS_W'(1);
      if (w_gnt_vld)     r_ptr <= w_gnt_sel;
      if (w_push)        r_wr <= r_wr + AW'(1);
      r_rd    <= w_rd_nxt;
      r_count <= w_cnt_nxt;
      r_drop  <= w_drop_nxt;
    end
  end

  // FIFO storage needs no reset; occupancy alone says what is valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= w_push_data;
  end

  // Registered head: bypass the write when the FIFO is (about to be) empty,
  // otherwise load the next entry; hold the last value while empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_id <= '0;
      r_out_ts <= '0;
    end else if (w_cnt_nxt != '0) begin
      if (r_count == '0 || (r_count == CNT_W'(1) && w_pop))
        {r_out_id, r_out_ts} <= w_push_data;
      else
        {r_out_id, r_out_ts} <= r_mem[w_rd_nxt];
    end
  end

  assign out_valid  = (r_count != '0);
  assign out_id     = r_out_id;
  assign out_ts     = r_out_ts;
  assign fifo_count = r_count;
  assign drop_count = r_drop;
endmodule
